gpu_mem_coalescer: RTL and testbench
====================================

# gpu_mem_coalescer

Warp memory stage that sits directly downstream of the SIMT core's per-lane memory port. It accepts one warp-wide load or store (per-lane address, data and active mask) and serialises it onto a single-port memory. Lanes targeting the same address are merged into one memory access. It returns a warp-wide response when every active lane is satisfied.

## Interface
- NUM_THREADS, 4, lanes per warp (≥1)
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 16, memory address width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  warp request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_mask  in  NUM_THREADS  active lanes (exec mask)
- req_addr  in  NUM_THREADS×ADDR_WIDTH  per-lane address
- req_wdata  in  NUM_THREADS×DATA_WIDTH  per-lane store data
- mem_req_valid  out  1  memory access request
- mem_req_ready  in  1  memory accepts request this cycle
- mem_we  out  1  access is a write
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rvalid  in  1  read data valid (one per accepted read, in order)
- mem_rdata  in  DATA_WIDTH  read data
- rsp_valid  out  1  one-cycle pulse, warp complete
- rsp_rdata  out  NUM_THREADS×DATA_WIDTH  per-lane load result
- rsp_mask  out  NUM_THREADS  copy of captured req_mask

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture we, mask, addr, wdata, and set pending=mask. Clear rsp_rdata to 0. Go to ISSUE, or to RESP if mask==0, which produces zero memory accesses.
- Leader = lowest-numbered set bit of pending. Group = all pending lanes whose addr equals addr[leader]; the comparison is full ADDR_WIDTH and purely combinational.
- ISSUE: mem_req_valid=1, mem_addr=addr[leader], mem_we=we.
  - Store: mem_wdata = wdata of the highest-numbered lane in the group, so the highest lane wins on an address conflict.
  - Load: mem_wdata = 0.
  - On mem_req_ready, clear the group from pending.
  - Store then goes to RESP if pending is now 0, else stays in ISSUE.
  - Load latches the group and goes to WAIT.
- mem_req_valid and its address/data stay stable until mem_req_ready. A request is never withdrawn.
- WAIT: mem_req_valid=0. On mem_rvalid, write mem_rdata into rsp_rdata for every lane of the latched group. Then go to RESP if pending==0, else ISSUE. At most one read is outstanding.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_mask hold until the next accepted request.
  - Stores: rsp_rdata is all zero.
  - Inactive lanes: rsp_rdata is 0.
- mem_rvalid outside WAIT is ignored.
- Number of memory accesses = number of distinct addresses among active lanes.
- Reset (any state, asynchronous): return to IDLE and drop pending and the latched group. Outputs become req_ready=1, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_mask=0. The memory side is reset together, so no stale mem_rvalid arrives.

## Timing
- Cycle 0: request accepted in IDLE. Cycle 1: first mem_req_valid.
- Store, N distinct addresses, mem_req_ready tied high: accesses in cycles 1..N, rsp_valid in cycle N+1, req_ready high in cycle N+2.
- Load, read latency L cycles after acceptance (mem_rvalid at cycle issue+L): each group takes 1+L cycles. With N groups, rsp_valid = 1 + N(1+L).
- Empty mask: rsp_valid in cycle 1, req_ready high in cycle 2.
- No combinational path from mem_rvalid/mem_rdata to mem_req_valid. rsp_* outputs are registered.

## Test plan
- Store, mask=4'b1111, addr={10,11,12,13}, wdata={A,B,C,D}, ready tied 1 -> 4 writes in lane order (10:A…13:D) in cycles 1-4, rsp_valid in cycle 5.
- Load, mask=4'b1111, all addr=0x20, memory returns 0x55AA with L=1 -> exactly 1 read, rsp_rdata all 0x55AA, rsp_valid in cycle 3.
- Load, mask=4'b0101, addr={5,9,5,9} -> one read of 5 only; lanes 0 and 2 get data, lanes 1 and 3 read 0; rsp_mask=4'b0101.
- Store conflict, mask=4'b1111, all addr=7, wdata={1,2,3,4} -> single write, mem[7]=4.
- Backpressure: mem_req_ready low for 3 cycles during the first store -> mem_req_valid, mem_addr and mem_wdata stable throughout; no duplicate write.
- mask=0 -> no mem_req_valid, rsp_valid in cycle 1. Assert rst while in WAIT -> all outputs at reset values immediately; next request behaves normally.

Source files
------------

// File: rtl/gpu_mem_coalescer_if.sv
// Warp memory-stage bundle: core-side request/response plus single-port memory request/read-return.
// slave is the coalescer's view; master is the environment (core + memory) view.
interface gpu_mem_coalescer_if #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16
);
    logic                                   req_valid;
    logic                                   req_ready;
    logic                                   req_we;
    logic [NUM_THREADS-1:0]                 req_mask;
    logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_wdata;

    logic                                   mem_req_valid;
    logic                                   mem_req_ready;
    logic                                   mem_we;
    logic [ADDR_WIDTH-1:0]                  mem_addr;
    logic [DATA_WIDTH-1:0]                  mem_wdata;
    logic                                   mem_rvalid;
    logic [DATA_WIDTH-1:0]                  mem_rdata;

    logic                                   rsp_valid;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rsp_rdata;
    logic [NUM_THREADS-1:0]                 rsp_mask;

    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_mask
    );

    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_mask
    );
endinterface

// File: rtl/gpu_mem_coalescer.sv
// Warp memory coalescer: serialises one warp access onto a single-port memory, one access per distinct address.
// Latency 1+groups (store) or 1+groups*(1+L) (load); req_ready only in IDLE, mem requests held until mem_req_ready.
module gpu_mem_coalescer #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    gpu_mem_coalescer_if.slave bus
);
    typedef logic [NUM_THREADS-1:0]                 lane_mask_t;
    typedef logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] lane_addr_t;
    typedef logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] lane_data_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state;
    logic                  we_q;
    lane_mask_t            pending;
    lane_mask_t            grp_q;
    lane_addr_t            addr_q;
    lane_data_t            wdata_q;
    lane_data_t            rsp_rdata_q;
    lane_mask_t            rsp_mask_q;
    logic                  req_ready_q;
    logic                  mem_req_valid_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  rsp_valid_q;

    // Address of the lowest-numbered set lane (the group leader).
    function automatic logic [ADDR_WIDTH-1:0] lead_addr(input lane_mask_t p, input lane_addr_t a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--)
            if (p[i]) r = a[i];
        return r;
    endfunction

    function automatic lane_mask_t group_of(input lane_mask_t p, input lane_addr_t a);
        lane_mask_t            g;
        logic [ADDR_WIDTH-1:0] la;
        la = lead_addr(p, a);
        g  = '0;
        for (int i = 0; i < NUM_THREADS; i++)
            if (p[i] && (a[i] == la)) g[i] = 1'b1;
        return g;
    endfunction

    // Highest lane of the group supplies store data, so it wins address conflicts.
    function automatic logic [DATA_WIDTH-1:0] hi_data(input lane_mask_t g, input lane_data_t d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_THREADS; i++)
            if (g[i]) r = d[i];
        return r;
    endfunction

    lane_mask_t            acc_grp, cur_grp, nxt_pend, nxt_grp;
    logic [ADDR_WIDTH-1:0] acc_addr, cur_addr, nxt_addr;
    logic [DATA_WIDTH-1:0] acc_wdata, nxt_wdata;

    assign acc_grp   = group_of(bus.req_mask, bus.req_addr);
    assign acc_addr  = lead_addr(bus.req_mask, bus.req_addr);
    assign acc_wdata = hi_data(acc_grp, bus.req_wdata);
    assign cur_grp   = group_of(pending, addr_q);
    assign cur_addr  = lead_addr(pending, addr_q);
    assign nxt_pend  = pending & ~cur_grp;
    assign nxt_grp   = group_of(nxt_pend, addr_q);
    assign nxt_addr  = lead_addr(nxt_pend, addr_q);
    assign nxt_wdata = hi_data(nxt_grp, wdata_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            we_q            <= 1'b0;
            pending         <= '0;
            grp_q           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rsp_rdata_q     <= '0;
            rsp_mask_q      <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        pending     <= bus.req_mask;
                        rsp_rdata_q <= '0;
                        rsp_mask_q  <= bus.req_mask;
                        req_ready_q <= 1'b0;
                        if (bus.req_mask == '0) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state           <= S_ISSUE;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= bus.req_we;
                            mem_addr_q      <= acc_addr;
                            mem_wdata_q     <= bus.req_we ? acc_wdata : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        pending <= nxt_pend;
                        if (we_q) begin
                            if (nxt_pend == '0) begin
                                mem_req_valid_q <= 1'b0;
                                rsp_valid_q     <= 1'b1;
                                state           <= S_RESP;
                            end else begin
                                mem_addr_q  <= nxt_addr;
                                mem_wdata_q <= nxt_wdata;
                            end
                        end else begin
                            grp_q           <= cur_grp;
                            mem_req_valid_q <= 1'b0;
                            state           <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        for (int i = 0; i < NUM_THREADS; i++)
                            if (grp_q[i]) rsp_rdata_q[i] <= bus.mem_rdata;
                        if (pending == '0) begin
                            rsp_valid_q <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= cur_addr;
                            state           <= S_ISSUE;
                        end
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_mask      = rsp_mask_q;
endmodule

// File: tb/tb_gpu_mem_coalescer.sv
// Directed bench for gpu_mem_coalescer: core driver, memory model with 1-cycle read latency and hold-off control.
module tb_gpu_mem_coalescer;
    localparam int NT = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpu_mem_coalescer_if #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    gpu_mem_coalescer #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:255];
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    logic        log_we[$];
    int          log_cyc[$];
    int          hold_until = 0;
    bit          mem_stall  = 1'b0;
    int          stall_cnt  = 0;
    int          unstable   = 0;

    // Memory model: single port, read data one cycle after acceptance, optional request hold-off.
    initial begin
        logic s_vld, s_rdy, s_we, p_stalled, p_we;
        logic [15:0] s_a, s_d, p_a, p_d;
        int s_cyc;
        p_stalled = 1'b0; p_we = 1'b0; p_a = '0; p_d = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        forever begin
            @(posedge clk);
            s_vld = bus.mem_req_valid; s_rdy = bus.mem_req_ready; s_we = bus.mem_we;
            s_a = bus.mem_addr; s_d = bus.mem_wdata; s_cyc = cyc;
            if (p_stalled && (s_vld !== 1'b1 || s_a !== p_a || s_d !== p_d || s_we !== p_we))
                unstable++;
            p_stalled = s_vld && !s_rdy && !rst;
            p_a = s_a; p_d = s_d; p_we = s_we;
            if (p_stalled) stall_cnt++;
            #1;
            bus.mem_rvalid    = 1'b0;
            bus.mem_rdata     = '0;
            bus.mem_req_ready = (cyc >= hold_until);
            if (s_vld && s_rdy && !rst) begin
                log_addr.push_back(s_a); log_data.push_back(s_d);
                log_we.push_back(s_we);  log_cyc.push_back(s_cyc);
                if (s_we) mem[s_a[7:0]] = s_d;
                else if (!mem_stall) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem[s_a[7:0]];
                end
            end
        end
    end

    int          rsp_rel, npulse, acc;
    logic        rdy_rsp, rdy_after;
    logic [3:0][15:0] exp_d;

    task automatic run_req(input logic we, input logic [3:0] mask, input logic [3:0][15:0] a,
                           input logic [3:0][15:0] d, input int hold);
        @(negedge clk);
        log_addr.delete(); log_data.delete(); log_we.delete(); log_cyc.delete();
        stall_cnt = 0; unstable = 0;
        acc = cyc; hold_until = cyc + hold;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_mask = mask;
        bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_mask = '0;
        rsp_rel = -1; npulse = 0; rdy_rsp = 1'b1; rdy_after = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                npulse++;
                if (rsp_rel < 0) begin rsp_rel = cyc - acc; rdy_rsp = bus.req_ready; end
            end else if (rsp_rel >= 0 && cyc - acc == rsp_rel + 1) begin
                rdy_after = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got vld=%b we=%b want 0/0", bus.mem_req_valid, bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 64'h0 || bus.rsp_mask !== 4'h0) begin n_fail++; $display("FAIL reset_rsp: got vld=%b rdata=%h mask=%b want 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_mask); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_store_distinct();
        run_req(1'b1, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10}, {16'hD, 16'hC, 16'hB, 16'hA}, 0);
        n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL store_count: got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4; i++) if (i < log_addr.size()) begin
            n_checks++;
            if (log_addr[i] !== 16'(10 + i) || log_data[i] !== 16'(16'hA + i) || log_we[i] !== 1'b1 || log_cyc[i] - acc != i + 1) begin
                n_fail++; $display("FAIL store_write%0d: got addr=%0d data=%h we=%b cyc=%0d want addr=%0d data=%h we=1 cyc=%0d",
                                   i, log_addr[i], log_data[i], log_we[i], log_cyc[i] - acc, 10 + i, 16'hA + i, i + 1);
            end
        end
        n_checks++; if (rsp_rel != 5 || npulse != 1) begin n_fail++; $display("FAIL store_rsp_cycle: got cyc=%0d pulses=%0d want 5/1", rsp_rel, npulse); end
        n_checks++; if (rdy_rsp !== 1'b0 || rdy_after !== 1'b1) begin n_fail++; $display("FAIL store_req_ready: got rsp=%b after=%b want 0/1", rdy_rsp, rdy_after); end
        n_checks++; if (bus.rsp_rdata !== 64'h0 || bus.rsp_mask !== 4'b1111) begin n_fail++; $display("FAIL store_rsp_data: got rdata=%h mask=%b want 0/1111", bus.rsp_rdata, bus.rsp_mask); end
    endtask

    task automatic test_load_same();
        run_req(1'b0, 4'b1111, {4{16'h0020}}, {4{16'hFFFF}}, 0);
        n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL load_same_count: got %0d want 1", log_addr.size()); end
        else begin
            n_checks++; if (log_addr[0] !== 16'h20 || log_we[0] !== 1'b0 || log_data[0] !== 16'h0) begin n_fail++; $display("FAIL load_same_req: got addr=%h we=%b wdata=%h want 20/0/0", log_addr[0], log_we[0], log_data[0]); end
        end
        n_checks++; if (rsp_rel != 3) begin n_fail++; $display("FAIL load_same_rsp_cycle: got %0d want 3", rsp_rel); end
        n_checks++; if (bus.rsp_rdata !== {4{16'h55AA}}) begin n_fail++; $display("FAIL load_same_data: got %h want %h", bus.rsp_rdata, {4{16'h55AA}}); end
    endtask

    task automatic test_load_partial();
        run_req(1'b0, 4'b0101, {16'd9, 16'd5, 16'd9, 16'd5}, '0, 0);
        n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", log_addr.size()); end
        else begin
            n_checks++; if (log_addr[0] !== 16'd5) begin n_fail++; $display("FAIL partial_addr: got %0d want 5", log_addr[0]); end
        end
        exp_d = {16'h0, 16'h1234, 16'h0, 16'h1234};
        n_checks++; if (bus.rsp_rdata !== exp_d) begin n_fail++; $display("FAIL partial_data: got %h want %h", bus.rsp_rdata, exp_d); end
        n_checks++; if (bus.rsp_mask !== 4'b0101 || rsp_rel != 3) begin n_fail++; $display("FAIL partial_rsp: got mask=%b cyc=%0d want 0101/3", bus.rsp_mask, rsp_rel); end
    endtask

    task automatic test_load_multi();
        run_req(1'b0, 4'b1111, {16'd3, 16'd1, 16'd2, 16'd1}, '0, 0);
        n_checks++; if (log_addr.size() != 3) begin n_fail++; $display("FAIL multi_count: got %0d want 3", log_addr.size()); end
        for (int i = 0; i < 3; i++) if (i < log_addr.size()) begin
            n_checks++;
            if (log_addr[i] !== 16'(i + 1) || log_cyc[i] - acc != 2 * i + 1) begin
                n_fail++; $display("FAIL multi_read%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i, log_addr[i], log_cyc[i] - acc, i + 1, 2 * i + 1);
            end
        end
        exp_d = {16'h0333, 16'h0111, 16'h0222, 16'h0111};
        n_checks++; if (bus.rsp_rdata !== exp_d || rsp_rel != 7) begin n_fail++; $display("FAIL multi_rsp: got data=%h cyc=%0d want %h/7", bus.rsp_rdata, rsp_rel, exp_d); end
    endtask

    task automatic test_store_conflict();
        run_req(1'b1, 4'b1111, {4{16'd7}}, {16'd4, 16'd3, 16'd2, 16'd1}, 0);
        n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL conflict_count: got %0d want 1", log_addr.size()); end
        n_checks++; if (mem[7] !== 16'd4) begin n_fail++; $display("FAIL conflict_mem7: got %0d want 4", mem[7]); end
        n_checks++; if (rsp_rel != 2) begin n_fail++; $display("FAIL conflict_rsp_cycle: got %0d want 2", rsp_rel); end
    endtask

    task automatic test_backpressure();
        run_req(1'b1, 4'b1111, {16'h43, 16'h42, 16'h41, 16'h40}, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4);
        n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_cnt); end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", log_addr.size()); end
        else begin
            n_checks++; if (log_addr[0] !== 16'h40 || log_data[0] !== 16'h1111 || log_cyc[0] - acc != 4) begin n_fail++; $display("FAIL bp_first: got addr=%h data=%h cyc=%0d want 40/1111/4", log_addr[0], log_data[0], log_cyc[0] - acc); end
        end
        n_checks++; if (rsp_rel != 8) begin n_fail++; $display("FAIL bp_rsp_cycle: got %0d want 8", rsp_rel); end
    endtask

    task automatic test_empty();
        run_req(1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, '0, 0);
        n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", log_addr.size()); end
        n_checks++; if (rsp_rel != 1 || npulse != 1) begin n_fail++; $display("FAIL empty_rsp: got cyc=%0d pulses=%0d want 1/1", rsp_rel, npulse); end
        n_checks++; if (rdy_after !== 1'b1 || bus.rsp_mask !== 4'b0) begin n_fail++; $display("FAIL empty_ready: got rdy=%b mask=%b want 1/0000", rdy_after, bus.rsp_mask); end
    endtask

    task automatic test_reset_in_wait();
        mem_stall = 1'b1;
        @(negedge clk);
        hold_until = cyc;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_mask = 4'b0001;
        bus.req_addr = {16'd0, 16'd0, 16'd0, 16'd3}; bus.req_wdata = '0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 16'd3) begin n_fail++; $display("FAIL rstw_issue: got vld=%b addr=%0d want 1/3", bus.mem_req_valid, bus.mem_addr); end
        @(negedge clk);
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rstw_wait: got vld=%b rdy=%b want 0/0", bus.mem_req_valid, bus.req_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 16'h0 || bus.rsp_mask !== 4'h0 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstw_outputs: got rdy=%b vld=%b addr=%h mask=%b rsp=%b want 1/0/0/0/0", bus.req_ready, bus.mem_req_valid, bus.mem_addr, bus.rsp_mask, bus.rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 4'b1000, {16'h20, 16'd0, 16'd0, 16'd0}, '0, 0);
        exp_d = {16'h55AA, 16'h0, 16'h0, 16'h0};
        n_checks++; if (bus.rsp_rdata !== exp_d || rsp_rel != 3 || log_addr.size() != 1) begin n_fail++; $display("FAIL after_reset_load: got data=%h cyc=%0d reads=%0d want %h/3/1", bus.rsp_rdata, rsp_rel, log_addr.size(), exp_d); end
        run_req(1'b1, 4'b0011, {16'd0, 16'd0, 16'd0, 16'h20}, {16'd0, 16'd0, 16'h7777, 16'h6666}, 0);
        n_checks++; if (mem[8'h20] !== 16'h6666 || mem[0] !== 16'h7777 || rsp_rel != 3) begin n_fail++; $display("FAIL b2b_store: got m20=%h m0=%h cyc=%0d want 6666/7777/3", mem[8'h20], mem[0], rsp_rel); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h20] = 16'h55AA; mem[5] = 16'h1234; mem[9] = 16'h9999;
        mem[1] = 16'h0111; mem[2] = 16'h0222; mem[3] = 16'h0333;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_mask = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_store_distinct();
        test_load_same();
        test_load_partial();
        test_load_multi();
        test_store_conflict();
        test_backpressure();
        test_empty();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
